// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: digit-serial add/subtract sequencer.
// One 4-bit adder slice is reused for WIDTH/4 cycles, least significant digit first.
// Operands are taken on a valid/ready request port. The sum and flags are returned
// on a valid/ready result port and held stable until the result is consumed.
module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NDIG = WIDTH / 4;
    localparam int CW   = $clog2(NDIG) + 1;

    generate
        if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 4-bit adder slice: returns {carry_out, sum[3:0]}
    function automatic logic [4:0] adder_4bits(input logic [3:0] a, input logic [3:0] b,
                                               input logic ci);
        adder_4bits = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    endfunction

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             a_msb_r;
    logic             b_msb_r;

    logic [4:0]       slice_s;
    logic [WIDTH-1:0] sum_next_s;
    logic [WIDTH-1:0] b_in_s;

    // Slice result for the current digit, the shifted partial sum, and the conditioned b operand
    always_comb begin
        slice_s    = adder_4bits(a_r[3:0], b_r[3:0], carry_r);
        sum_next_s = (out_sum >> 3'd4) | (WIDTH'(slice_s[3:0]) << (WIDTH - 4));
        b_in_s     = in_sub ? ~in_b : in_b;
    end

    // Sequencer FSM: accept operands, run one digit per cycle, hold the result until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            carry_r   <= 1'b0;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            a_msb_r   <= 1'b0;
            b_msb_r   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= {WIDTH{1'b0}};
            out_co    <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= in_a;
                        b_r      <= b_in_s;
                        carry_r  <= in_sub;
                        cnt_r    <= {CW{1'b0}};
                        a_msb_r  <= in_a[WIDTH-1];
                        b_msb_r  <= b_in_s[WIDTH-1];
                        in_ready <= 1'b0;
                        state_r  <= RUN;
                    end
                end
                RUN: begin
                    carry_r <= slice_s[4];
                    a_r     <= a_r >> 3'd4;
                    b_r     <= b_r >> 3'd4;
                    out_sum <= sum_next_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (cnt_r == CW'(NDIG - 1)) begin
                        // Last digit: the flags come from the final slice and the completed sum
                        out_co    <= slice_s[4];
                        out_ovf   <= (a_msb_r == b_msb_r) & (slice_s[3] != a_msb_r);
                        out_zero  <= (sum_next_s == {WIDTH{1'b0}});
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
